cpu_step_ctrl: RTL

CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

---
 rtl/cpu_step_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: clean single-step / auto-run clock for a pipelined CPU,
// fed by a debounced push button or a selectable-rate period timer.
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HIGH_CYCLES     = 4,
    parameter int LOW_CYCLES      = 4,
    parameter int PERIOD_BASE     = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_step,
    input  logic        run_en,
    input  logic [1:0]  rate_sel,
    input  logic        halt,
    input  logic        cnt_clr,
    output logic        cpu_clk,
    output logic [15:0] step_cnt,
    output logic        busy,
    output logic        btn_db
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(PERIOD_BASE * 64 + 1);
    localparam int TW = $clog2((HIGH_CYCLES > LOW_CYCLES ? HIGH_CYCLES : LOW_CYCLES) + 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t        state, state_n;
    logic          sync0, sync1, db_q;
    logic [DW-1:0] db_cnt;
    logic [PW-1:0] pcnt, period;
    logic [1:0]    rate_q;
    logic [TW-1:0] tcnt;
    logic          pend, pend_auto, pend_n, pend_auto_n;
    logic          run, man_req, auto_req, req, pend_eff, phase_end, enter_high;

    // 3 - rate_sel is simply ~rate_sel on two bits; shift by twice that
    assign period     = PW'(PERIOD_BASE) << {~rate_sel, 1'b0};
    assign run        = run_en && !halt && rate_sel == rate_q;
    assign auto_req   = run && pcnt == period - PW'(1);
    assign man_req    = btn_db && !db_q && !run_en;
    assign req        = man_req || auto_req;
    assign pend_eff   = pend && !(halt && pend_auto);
    assign phase_end  = tcnt == TW'((state == HIGH ? HIGH_CYCLES : LOW_CYCLES) - 1);
    assign enter_high = state_n == HIGH && state != HIGH;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync0  <= 1'b0;
            sync1  <= 1'b0;
            db_q   <= 1'b0;
            btn_db <= 1'b0;
            db_cnt <= '0;
            rate_q <= 2'd0;
            pcnt   <= '0;
        end else begin
            sync0  <= btn_step;
            sync1  <= sync0;
            db_q   <= btn_db;
            rate_q <= rate_sel;
            if (sync1 == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt <= '0;
                btn_db <= sync1;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
            pcnt <= (!run || auto_req) ? '0 : pcnt + PW'(1);
        end
    end

    // a request seen in the last LOW cycle starts the next pulse directly
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (req || pend_eff) ? HIGH : IDLE;
            HIGH:    state_n = phase_end ? LOW : HIGH;
            LOW:     state_n = phase_end ? ((req || pend_eff) ? HIGH : IDLE) : LOW;
            default: state_n = IDLE;
        endcase
    end

    assign pend_n      = enter_high ? 1'b0 : pend_eff || (req && state != IDLE);
    assign pend_auto_n = pend_eff ? pend_auto : !man_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tcnt      <= '0;
            pend      <= 1'b0;
            pend_auto <= 1'b0;
            cpu_clk   <= 1'b0;
            busy      <= 1'b0;
            step_cnt  <= 16'd0;
        end else begin
            state     <= state_n;
            tcnt      <= (state_n != state) ? '0 : tcnt + TW'(1);
            pend      <= pend_n;
            pend_auto <= pend_auto_n;
            cpu_clk   <= state_n == HIGH;
            busy      <= state_n != IDLE;
            step_cnt  <= cnt_clr ? 16'd0 : step_cnt + 16'(enter_high);
        end
    end
endmodule
